// File: rtl/adsr_pkg.sv
// Shared constants for the ADSR envelope controller:
// phase codes and default gain format.
package adsr_pkg;

  localparam int GAIN_W_DEF = 16;
  localparam logic [GAIN_W_DEF-1:0] GAIN_MAX_DEF = 16'h7FFF;
  localparam logic [GAIN_W_DEF-1:0] SUS_CLAMP = GAIN_MAX_DEF;

  localparam logic [2:0] PH_IDLE    = 3'd0;
  localparam logic [2:0] PH_ATTACK  = 3'd1;
  localparam logic [2:0] PH_DECAY   = 3'd2;
  localparam logic [2:0] PH_SUSTAIN = 3'd3;
  localparam logic [2:0] PH_RELEASE = 3'd4;

endpackage

// File: rtl/adsr_step_unit.sv
// Saturating envelope step toward a target level.
// dir=1 steps up, dir=0 steps down; step 0 reaches at once.
module adsr_step_unit #(
  parameter int W = 16
) (
  input  logic [W-1:0] level,
  input  logic [W-1:0] step,
  input  logic [W-1:0] target,
  input  logic         dir,
  output logic [W-1:0] next_level,
  output logic         reached
);

  logic [W:0] lvl_x;
  logic [W:0] stp_x;
  logic [W:0] tgt_x;

  assign lvl_x = {1'b0, level};
  assign stp_x = {1'b0, step};
  assign tgt_x = {1'b0, target};

  // Compare in W+1 bits so neither side can wrap.
  always_comb begin
    if (step == '0)
      reached = 1'b1;
    else if (dir)
      reached = (lvl_x + stp_x) >= tgt_x;
    else
      reached = lvl_x <= (tgt_x + stp_x);
  end

  always_comb begin
    if (reached)
      next_level = target;
    else if (dir)
      next_level = level + step;
    else
      next_level = level - step;
  end

endmodule

// File: rtl/adsr_env_ctrl.sv
// ADSR envelope sequencer: note events drive a five-phase FSM,
// one level step per sample strobe, registered Q1.15 gain out.
module adsr_env_ctrl
  import adsr_pkg::*;
#(
  parameter int GAIN_W = GAIN_W_DEF,
  parameter logic [GAIN_W-1:0] GAIN_MAX = GAIN_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_ready,
  input  logic              note_on,
  input  logic              note_off,
  input  logic [GAIN_W-1:0] attack_step,
  input  logic [GAIN_W-1:0] decay_step,
  input  logic [GAIN_W-1:0] sustain_level,
  input  logic [GAIN_W-1:0] release_step,
  output logic [GAIN_W-1:0] env_gain,
  output logic              gain_valid,
  output logic [2:0]        phase,
  output logic              env_busy
);

  logic [GAIN_W-1:0] att_q;
  logic [GAIN_W-1:0] dec_q;
  logic [GAIN_W-1:0] sus_q;
  logic [GAIN_W-1:0] rel_q;
  logic [GAIN_W-1:0] sus_in;

  logic [GAIN_W-1:0] stp;
  logic [GAIN_W-1:0] tgt;
  logic [GAIN_W-1:0] nxt;
  logic              dir;
  logic              reached;

  logic [2:0]        ph_n;
  logic [GAIN_W-1:0] lvl_n;
  logic              held;

  assign sus_in = (sustain_level > GAIN_MAX) ? GAIN_MAX : sustain_level;

  assign held = (phase == PH_ATTACK) ||
                (phase == PH_DECAY)  ||
                (phase == PH_SUSTAIN);

  always_comb begin
    stp = rel_q;
    tgt = '0;
    dir = 1'b0;
    case (phase)
      PH_ATTACK: begin
        stp = att_q;
        tgt = GAIN_MAX;
        dir = 1'b1;
      end
      PH_DECAY: begin
        stp = dec_q;
        tgt = sus_q;
      end
      default: ;
    endcase
  end

  adsr_step_unit #(.W(GAIN_W)) u_step (
    .level      (env_gain),
    .step       (stp),
    .target     (tgt),
    .dir        (dir),
    .next_level (nxt),
    .reached    (reached)
  );

  // Events override the tick; level is kept for legato retrigger.
  always_comb begin
    ph_n  = phase;
    lvl_n = env_gain;
    if (note_on)
      ph_n = PH_ATTACK;
    else if (note_off && held)
      ph_n = PH_RELEASE;
    else if (in_ready) begin
      case (phase)
        PH_ATTACK: begin
          lvl_n = nxt;
          if (reached) ph_n = PH_DECAY;
        end
        PH_DECAY: begin
          lvl_n = nxt;
          if (reached) ph_n = PH_SUSTAIN;
        end
        PH_SUSTAIN: lvl_n = sus_q;
        PH_RELEASE: begin
          lvl_n = nxt;
          if (reached) ph_n = PH_IDLE;
        end
        default: begin
          ph_n  = PH_IDLE;
          lvl_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= PH_IDLE;
      env_gain   <= '0;
      gain_valid <= 1'b0;
      env_busy   <= 1'b0;
      att_q      <= '0;
      dec_q      <= '0;
      sus_q      <= '0;
      rel_q      <= '0;
    end else begin
      phase      <= ph_n;
      env_gain   <= lvl_n;
      gain_valid <= in_ready;
      env_busy   <= (ph_n != PH_IDLE);
      if (note_on) begin
        att_q <= attack_step;
        dec_q <= decay_step;
        sus_q <= sus_in;
        rel_q <= release_step;
      end
    end
  end

endmodule

// File: tb/tb_adsr_env_ctrl.sv
// Directed bench for adsr_env_ctrl with hand-computed gains.
module tb_adsr_env_ctrl;

  logic        clk;
  logic        reset;
  logic        in_ready;
  logic        note_on;
  logic        note_off;
  logic [15:0] attack_step;
  logic [15:0] decay_step;
  logic [15:0] sustain_level;
  logic [15:0] release_step;
  logic [15:0] env_gain;
  logic        gain_valid;
  logic [2:0]  phase;
  logic        env_busy;

  int checks   = 0;
  int failures = 0;

  logic [15:0] ads_g [9] = '{16'h2000, 16'h4000, 16'h6000, 16'h7FFF,
                             16'h6FFF, 16'h5FFF, 16'h4FFF, 16'h4000,
                             16'h4000};
  logic [2:0]  ads_p [9] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2,
                             3'd3, 3'd3};
  logic [15:0] rel_g [3] = '{16'h2800, 16'h1000, 16'h0000};
  logic [2:0]  rel_p [3] = '{3'd4, 3'd4, 3'd0};

  adsr_env_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .in_ready      (in_ready),
    .note_on       (note_on),
    .note_off      (note_off),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .env_gain      (env_gain),
    .gain_valid    (gain_valid),
    .phase         (phase),
    .env_busy      (env_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    note_on  = 1'b0;
    note_off = 1'b0;
  endtask

  task automatic tick();
    in_ready = 1'b1;
    cyc();
    in_ready = 1'b0;
  endtask

  task automatic gap();
    repeat (9) cyc();
  endtask

  task automatic cfg(input logic [15:0] a, input logic [15:0] d,
                     input logic [15:0] s, input logic [15:0] r);
    attack_step   = a;
    decay_step    = d;
    sustain_level = s;
    release_step  = r;
  endtask

  initial begin
    reset    = 1'b1;
    in_ready = 1'b0;
    note_on  = 1'b0;
    note_off = 1'b0;
    cfg(16'h0, 16'h0, 16'h0, 16'h0);
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_phase", phase, 0);
    chk("rst_gain", env_gain, 0);
    chk("rst_valid", gain_valid, 0);
    chk("rst_busy", env_busy, 0);

    // attack / decay / sustain
    cfg(16'h2000, 16'h1000, 16'h4000, 16'h1800);
    note_on = 1'b1;
    cyc();
    chk("on_phase", phase, 1);
    chk("on_busy", env_busy, 1);
    chk("on_gain", env_gain, 0);
    chk("on_valid", gain_valid, 0);
    cfg(16'h0001, 16'h0001, 16'h0001, 16'h0001);
    gap();
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("ads_gain", env_gain, ads_g[i]);
      chk("ads_phase", phase, ads_p[i]);
      chk("ads_valid", gain_valid, 1);
      gap();
    end
    chk("ads_valid_low", gain_valid, 0);

    // release
    note_off = 1'b1;
    cyc();
    chk("off_phase", phase, 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rel_gain", env_gain, rel_g[i]);
      chk("rel_phase", phase, rel_p[i]);
      gap();
    end
    chk("rel_busy", env_busy, 0);

    // zero steps are instant
    cfg(16'h0, 16'h0, 16'h3000, 16'h2000);
    note_on = 1'b1;
    cyc();
    tick();
    chk("z1_gain", env_gain, 16'h7FFF);
    chk("z1_phase", phase, 2);
    tick();
    chk("z2_gain", env_gain, 16'h3000);
    chk("z2_phase", phase, 3);

    // release to 1000, then legato retrigger
    note_off = 1'b1;
    cyc();
    tick();
    chk("zr_gain", env_gain, 16'h1000);
    chk("zr_phase", phase, 4);
    cfg(16'h0100, 16'h0, 16'h3000, 16'h2000);
    note_on = 1'b1;
    cyc();
    chk("leg_phase", phase, 1);
    chk("leg_gain", env_gain, 16'h1000);
    tick();
    chk("leg_up", env_gain, 16'h1100);

    // reset mid-attack
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mrst_phase", phase, 0);
    chk("mrst_gain", env_gain, 0);
    chk("mrst_busy", env_busy, 0);
    tick();
    chk("idle_gain", env_gain, 0);
    chk("idle_valid", gain_valid, 1);
    chk("idle_phase", phase, 0);

    // note_off in idle ignored
    note_off = 1'b1;
    cyc();
    chk("off_idle", phase, 0);

    // coincident note_on + note_off + in_ready
    cfg(16'h0800, 16'h0, 16'h0, 16'h0);
    note_on  = 1'b1;
    note_off = 1'b1;
    tick();
    chk("co_phase", phase, 1);
    chk("co_gain", env_gain, 0);
    chk("co_valid", gain_valid, 1);
    cyc();
    chk("co_valid_once", gain_valid, 0);
    tick();
    chk("co_next", env_gain, 16'h0800);

    // sustain above full scale is clamped
    cfg(16'h0, 16'h0, 16'hFFFF, 16'h0);
    note_on = 1'b1;
    cyc();
    tick();
    chk("cl_att", env_gain, 16'h7FFF);
    tick();
    chk("cl_dec", env_gain, 16'h7FFF);
    chk("cl_phase", phase, 3);
    tick();
    chk("cl_sus", env_gain, 16'h7FFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
